// File: rtl/atm_pkg.sv
// Shared constants for the ATM keypad entry block: key codes, FSM state
// encodings and the digit field width.
package atm_pkg;

  localparam int FIELD_W = 12;

  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_ENTER  = 4'hB;
  localparam logic [3:0] KEY_LANG   = 4'hC;
  localparam logic [3:0] KEY_CANCEL = 4'hF;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ACCT = 3'd1;
  localparam logic [2:0] ST_LANG = 3'd2;
  localparam logic [2:0] ST_PIN  = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/atm_digit_field.sv
// Nibble-per-digit shift field with a digit counter; clear wins over shift
// and digits beyond DIGITS are dropped.
module atm_digit_field
  import atm_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift,
  input  logic [3:0]         digit,
  output logic [FIELD_W-1:0] field,
  output logic               full
);

  localparam int CW = $clog2(DIGITS + 1);

  logic [FIELD_W-1:0] field_q, field_d;
  logic [CW-1:0]      count_q, count_d;

  assign full  = (count_q == CW'(DIGITS));
  assign field = field_q;

  always_comb begin
    field_d = field_q;
    count_d = count_q;
    if (clr) begin
      field_d = '0;
      count_d = '0;
    end else if (shift && !full) begin
      field_d = {field_q[FIELD_W-5:0], digit};
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      field_q <= '0;
      count_q <= '0;
    end else begin
      field_q <= field_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/atm_keypad_entry.sv
// ATM keypad entry sequencer: account digits, language, PIN, then hold until
// the ATM acknowledges. Define ENTRY_TIMEOUT_EN to abort idle entries.
//
// state   | meaning
// IDLE    | no card, all outputs cleared
// ACCT    | collecting account digits
// LANG    | waiting for language key C
// PIN     | collecting PIN digits
// HOLD    | entry complete, outputs frozen until entry_ack
module atm_keypad_entry
  import atm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int DIGITS         = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_in,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        entry_ack,
  output logic [11:0] Account_Number,
  output logic [11:0] PIN,
  output logic        LC,
  output logic        entry_valid,
  output logic        entry_error,
  output logic        busy
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [2:0] state_q, state_d;
  logic       lc_q, lc_d;
  logic       err_q, err_d;
  logic       acct_clr, acct_shift, acct_full;
  logic       pin_clr, pin_shift, pin_full;
  logic       abort, timeout, active;
  logic [FIELD_W-1:0] acct_field, pin_field;

  assign active = (state_q == ST_ACCT) || (state_q == ST_LANG) || (state_q == ST_PIN);

  atm_digit_field #(.DIGITS(DIGITS)) u_acct (
    .clk   (clk),
    .rst   (rst),
    .clr   (acct_clr),
    .shift (acct_shift),
    .digit (key_code),
    .field (acct_field),
    .full  (acct_full)
  );

  atm_digit_field #(.DIGITS(DIGITS)) u_pin (
    .clk   (clk),
    .rst   (rst),
    .clr   (pin_clr),
    .shift (pin_shift),
    .digit (key_code),
    .field (pin_field),
    .full  (pin_full)
  );

  always_comb begin
    state_d    = state_q;
    lc_d       = lc_q;
    err_d      = 1'b0;
    acct_clr   = 1'b0;
    acct_shift = 1'b0;
    pin_clr    = 1'b0;
    pin_shift  = 1'b0;
    abort      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (card_in) begin
          state_d  = ST_ACCT;
          acct_clr = 1'b1;
          pin_clr  = 1'b1;
          lc_d     = 1'b0;
        end
      end
      ST_ACCT: begin
        if (key_valid) begin
          case (key_code)
            KEY_CLEAR:  acct_clr = 1'b1;
            KEY_ENTER:  if (acct_full) state_d = ST_LANG; else err_d = 1'b1;
            KEY_CANCEL: abort = 1'b1;
            default:    acct_shift = is_digit(key_code);
          endcase
        end
      end
      ST_LANG: begin
        if (key_valid) begin
          if (key_code == KEY_LANG) begin
            state_d = ST_PIN;
            lc_d    = 1'b1;
          end else if (key_code == KEY_CANCEL) begin
            abort = 1'b1;
          end
        end
      end
      ST_PIN: begin
        if (key_valid) begin
          case (key_code)
            KEY_CLEAR:  pin_clr = 1'b1;
            KEY_ENTER:  if (pin_full) state_d = ST_HOLD; else err_d = 1'b1;
            KEY_CANCEL: abort = 1'b1;
            default:    pin_shift = is_digit(key_code);
          endcase
        end
      end
      ST_HOLD: begin
        if (entry_ack) begin
          state_d  = ST_IDLE;
          acct_clr = 1'b1;
          pin_clr  = 1'b1;
          lc_d     = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Card removal and timeout override whatever the key decode chose.
    if (timeout) abort = 1'b1;
    if (state_q != ST_IDLE && !card_in) abort = 1'b1;
    if (abort) begin
      state_d    = ST_IDLE;
      acct_clr   = 1'b1;
      pin_clr    = 1'b1;
      acct_shift = 1'b0;
      pin_shift  = 1'b0;
      lc_d       = 1'b0;
      err_d      = 1'b1;
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] RELOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer_q, timer_d;

  // Down-counter; terminal count with no key this cycle means the user stalled.
  assign timeout = active && !key_valid && (timer_q == '0);

  always_comb begin
    timer_d = timer_q - 1'b1;
    if (!active || key_valid || state_d != state_q) timer_d = RELOAD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lc_q    <= lc_d;
      err_q   <= err_d;
    end
  end

  assign Account_Number = acct_field;
  assign PIN            = pin_field;
  assign LC             = lc_q;
  assign entry_valid    = (state_q == ST_HOLD);
  assign entry_error    = err_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: doc/atm_keypad_entry.md
ATM_KEYPAD_ENTRY -- requirements
Module: atm_keypad_entry

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000: idle cycles allowed between key presses before abort.
REQ-002 Parameter DIGITS, default 3: digits per 12-bit field, one nibble per digit.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 card_in  input  1  card present level.
REQ-006 key_valid  input  1  one-cycle strobe qualifying key_code.
REQ-007 key_code  input  4  key: 0-9 digit, A clear, B enter, C language, F cancel; D and E ignored.
REQ-008 entry_ack  input  1  downstream ATM accepted the entry.
REQ-009 Account_Number  output  12  assembled account digits, MSD in [11:8].
REQ-010 PIN  output  12  assembled PIN digits, MSD in [11:8].
REQ-011 LC  output  1  language chosen.
REQ-012 entry_valid  output  1  Account_Number, PIN and LC complete and stable.
REQ-013 entry_error  output  1  one-cycle pulse on short enter, timeout or cancel.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 States SHALL be IDLE, ACCT, LANG, PIN, HOLD, encoded as 3 bits.
REQ-016 IDLE -> ACCT on first cycle with card_in=1; the field and digit count clear on entry.
REQ-017 Each digit in ACCT/PIN SHALL shift in as field={field[7:0],key_code}, count+1; digits while count==DIGITS are ignored.
REQ-018 Clear (A) SHALL zero the current field and count in the same cycle; other fields are unaffected.
REQ-019 Enter (B) with count==DIGITS: ACCT->LANG, PIN->HOLD; with count<DIGITS: stay and pulse entry_error.
REQ-020 In LANG only key C SHALL advance to PIN and set LC=1; all other keys except F are ignored.
REQ-021 In HOLD entry_valid=1, outputs frozen, keys ignored; entry_ack=1 -> IDLE with all outputs cleared next cycle.
REQ-022 Cancel (F) in ACCT/LANG/PIN, or card_in=0 in any non-IDLE state -> IDLE, outputs cleared, entry_error pulse; card removal outranks all keys in the same cycle.
REQ-023 Latency: a key SHALL be reflected on outputs one cycle after its key_valid; entry_valid rises one cycle after the accepting enter.
REQ-024 key_valid while IDLE or with card_in=0 SHALL have no effect.

Reset
REQ-025 rst SHALL force IDLE; Account_Number=0, PIN=0, LC=0, entry_valid=0, entry_error=0, busy=0, counts and timer=0, regardless of state mid-entry.

Configuration
REQ-026 With ENTRY_TIMEOUT_EN defined: a counter reloads on every key_valid and state entry; reaching TIMEOUT_CYCLES in ACCT/LANG/PIN -> IDLE, outputs cleared, entry_error pulse; HOLD never times out.
REQ-027 Without ENTRY_TIMEOUT_EN: no timer logic; entry waits indefinitely.

Structure
REQ-028 Shared package atm_pkg SHALL hold key code constants (KEY_CLEAR, KEY_ENTER, KEY_LANG, KEY_CANCEL), the state encodings and FIELD_W=12.
REQ-029 One sub-module atm_digit_field (12-bit shift field + digit counter, with clear/shift/full) SHALL be instanced twice, for account and PIN.

Verification
REQ-030 card_in=1, keys 1,2,3,B,C,4,5,6,B -> entry_valid=1, Account_Number=12'h123, PIN=12'h456, LC=1; entry_ack -> all 0 next cycle.
REQ-031 In ACCT keys 7,B -> entry_error pulse, state ACCT; then A,1,2,3,4,B -> Account_Number=12'h123 (digit 4 ignored), state LANG.
REQ-032 In PIN after digits 9,9, drop card_in together with key 9 -> IDLE, PIN=0, entry_error pulse, busy=0.
REQ-033 ENTRY_TIMEOUT_EN, TIMEOUT_CYCLES=10: in LANG no key for 10 cycles -> IDLE, entry_error pulse; key at cycle 9 restarts the count.
REQ-034 Assert rst mid-PIN entry (Account_Number=12'h321) -> all outputs 0 asynchronously; after release, card_in=1 restarts in ACCT.
REQ-035 In HOLD press F and digits without entry_ack for 20 cycles -> entry_valid stays 1, outputs unchanged.
